bullet_ctrl: RTL and testbench

//  Per-tank bullet engine; one instance per player, upstream of the colour mapper.

---
 rtl/tank_pkg.sv | 44 ++++
 rtl/rect_overlap.sv | 23 ++
 rtl/bullet_ctrl.sv | 236 +++++++++++++++++++++++
 tb/tb_bullet_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tank_pkg.sv
// rtl/tank_pkg.sv - shared types, screen geometry and direction helpers for the bullet engine
package tank_pkg;

   typedef enum logic [2:0] {
      DIR_NONE  = 3'b000,
      DIR_UP    = 3'b001,
      DIR_RIGHT = 3'b010,
      DIR_LEFT  = 3'b011,
      DIR_DOWN  = 3'b100
   } dir_t;

   typedef enum logic [1:0] {
      HIT_IDLE = 2'b00,
      HIT_FLY  = 2'b01,
      HIT_WALL = 2'b10,
      HIT_TANK = 2'b11
   } hit_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FLY,
      ST_HIT
   } state_t;

   localparam int SCREEN_W    = 640;
   localparam int SCREEN_H    = 480;
   localparam int TANK_SIZE   = 32;
   localparam int BULLET_SIZE = 8;

   function automatic logic dir_valid(input logic [2:0] d);
      return (d == DIR_UP) || (d == DIR_RIGHT) || (d == DIR_LEFT) || (d == DIR_DOWN);
   endfunction

   function automatic dir_t dir_reverse(input dir_t d);
      case (d)
         DIR_UP:    return DIR_DOWN;
         DIR_DOWN:  return DIR_UP;
         DIR_LEFT:  return DIR_RIGHT;
         DIR_RIGHT: return DIR_LEFT;
         default:   return d;
      endcase
   endfunction

endpackage

// File: rtl/rect_overlap.sv
// rtl/rect_overlap.sv - combinational axis-aligned box overlap test
module rect_overlap (
   input  logic [9:0] ax,
   input  logic [9:0] ay,
   input  logic [9:0] aw,
   input  logic [9:0] ah,
   input  logic [9:0] bx,
   input  logic [9:0] by,
   input  logic [9:0] bw,
   input  logic [9:0] bh,
   output logic       hit
);
   // 11-bit ends so boxes touching the right/bottom of the 10-bit range never wrap
   logic [10:0] w_ax_end, w_ay_end, w_bx_end, w_by_end;

   assign w_ax_end = {1'b0, ax} + {1'b0, aw};
   assign w_ay_end = {1'b0, ay} + {1'b0, ah};
   assign w_bx_end = {1'b0, bx} + {1'b0, bw};
   assign w_by_end = {1'b0, by} + {1'b0, bh};

   assign hit = ({1'b0, ax} < w_bx_end) && ({1'b0, bx} < w_ax_end) &&
                ({1'b0, ay} < w_by_end) && ({1'b0, by} < w_ay_end);
endmodule

// File: rtl/bullet_ctrl.sv
// rtl/bullet_ctrl.sv - per-tank bullet launch/flight/collision engine; optional BULLET_BOUNCE_EN
module bullet_ctrl
   import tank_pkg::*;
#(
   parameter int STEP       = 4,
   parameter int HIT_FRAMES = 8,
   parameter int COOLDOWN   = 16,
   parameter int WALL_H_W   = 64,
   parameter int WALL_H_H   = 16,
   parameter int WALL_V_W   = 32,
   parameter int WALL_V_H   = 64
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       frame_clk,
   input  logic       fire,
   input  logic [2:0] tank_dir,
   input  logic [9:0] tankX,
   input  logic [9:0] tankY,
   input  logic [9:0] oppX,
   input  logic [9:0] oppY,
   input  logic [9:0] wallX1,
   input  logic [9:0] wallX2,
   input  logic [9:0] wallX3,
   input  logic [9:0] wallX4,
   input  logic [9:0] wallY1,
   input  logic [9:0] wallY2,
   input  logic [9:0] wallY3,
   input  logic [9:0] wallY4,
   input  logic [9:0] DrawX,
   input  logic [9:0] DrawY,
   output logic [9:0] bulletX,
   output logic [9:0] bulletY,
   output logic [1:0] hit,
   output logic       is_bullet,
   output logic       score_pulse
);
   localparam int CW  = $clog2(COOLDOWN + 1);
   localparam int HCW = $clog2(HIT_FRAMES + 1);
   localparam logic [9:0]  L_STEP   = 10'(STEP);
   localparam logic [9:0]  L_BSIZE  = 10'(BULLET_SIZE);
   localparam logic [9:0]  L_TSIZE  = 10'(TANK_SIZE);
   localparam logic [9:0]  L_LAUNCH = 10'((TANK_SIZE - BULLET_SIZE) / 2);
   localparam logic [10:0] L_SCR_W  = 11'(SCREEN_W);
   localparam logic [10:0] L_SCR_H  = 11'(SCREEN_H);

   logic            r_f1, r_f2, r_f3;
   logic            w_tick;
   state_t          r_state, w_state_nxt;
   logic [9:0]      r_bx, r_by, w_bx_nxt, w_by_nxt;
   hit_t            r_hit, w_hit_nxt;
   dir_t            r_dir, w_dir_nxt;
   logic [CW-1:0]   r_cool, w_cool_nxt;
   logic [HCW-1:0]  r_hcnt, w_hcnt_nxt;
   logic            r_score, w_score_nxt;
`ifdef BULLET_BOUNCE_EN
   logic            r_bounce, w_bounce_nxt;
`endif

   logic [9:0]      w_mx, w_my;
   logic            w_underflow, w_edge;
   logic [3:0]      w_wall_hit;
   logic            w_opp_ov, w_opp_hit, w_block;
   logic [9:0]      w_wx [4];
   logic [9:0]      w_wy [4];

   // frame_clk is asynchronous: two-flop synchroniser, third flop for the edge
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_f1 <= 1'b0;
         r_f2 <= 1'b0;
         r_f3 <= 1'b0;
      end else begin
         r_f1 <= frame_clk;
         r_f2 <= r_f1;
         r_f3 <= r_f2;
      end
   end
   assign w_tick = r_f2 & ~r_f3;

   // Candidate next position; up/left flag underflow instead of wrapping
   always_comb begin
      w_mx        = r_bx;
      w_my        = r_by;
      w_underflow = 1'b0;
      w_edge      = 1'b0;
      case (r_dir)
         DIR_UP: begin
            w_underflow = (r_by < L_STEP);
            w_my        = r_by - L_STEP;
         end
         DIR_DOWN: begin
            w_my   = r_by + L_STEP;
            w_edge = ({1'b0, w_my} + {1'b0, L_BSIZE}) > L_SCR_H;
         end
         DIR_LEFT: begin
            w_underflow = (r_bx < L_STEP);
            w_mx        = r_bx - L_STEP;
         end
         DIR_RIGHT: begin
            w_mx   = r_bx + L_STEP;
            w_edge = ({1'b0, w_mx} + {1'b0, L_BSIZE}) > L_SCR_W;
         end
         default: ;
      endcase
   end

   assign w_wx = '{wallX1, wallX2, wallX3, wallX4};
   assign w_wy = '{wallY1, wallY2, wallY3, wallY4};

   for (genvar g = 0; g < 4; g++) begin : g_wall
      // walls 1 and 3 are horizontal, 2 and 4 vertical
      localparam logic [9:0] L_WW = (g % 2 == 0) ? 10'(WALL_H_W) : 10'(WALL_V_W);
      localparam logic [9:0] L_WH = (g % 2 == 0) ? 10'(WALL_H_H) : 10'(WALL_V_H);
      rect_overlap u_wall (
         .ax (w_mx),   .ay (w_my),   .aw (L_BSIZE), .ah (L_BSIZE),
         .bx (w_wx[g]), .by (w_wy[g]), .bw (L_WW),   .bh (L_WH),
         .hit(w_wall_hit[g])
      );
   end

   rect_overlap u_opp (
      .ax (w_mx), .ay (w_my), .aw (L_BSIZE), .ah (L_BSIZE),
      .bx (oppX), .by (oppY), .bw (L_TSIZE), .bh (L_TSIZE),
      .hit(w_opp_ov)
   );

   assign w_opp_hit = w_opp_ov & ~w_underflow;
   assign w_block   = w_underflow | w_edge | (|w_wall_hit);

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state <= ST_IDLE;
         r_bx    <= '0;
         r_by    <= '0;
         r_hit   <= HIT_IDLE;
         r_dir   <= DIR_UP;
         r_cool  <= '0;
         r_hcnt  <= '0;
         r_score <= 1'b0;
`ifdef BULLET_BOUNCE_EN
         r_bounce <= 1'b0;
`endif
      end else begin
         r_state <= w_state_nxt;
         r_bx    <= w_bx_nxt;
         r_by    <= w_by_nxt;
         r_hit   <= w_hit_nxt;
         r_dir   <= w_dir_nxt;
         r_cool  <= w_cool_nxt;
         r_hcnt  <= w_hcnt_nxt;
         r_score <= w_score_nxt;
`ifdef BULLET_BOUNCE_EN
         r_bounce <= w_bounce_nxt;
`endif
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_bx_nxt    = r_bx;
      w_by_nxt    = r_by;
      w_hit_nxt   = r_hit;
      w_dir_nxt   = r_dir;
      w_cool_nxt  = r_cool;
      w_hcnt_nxt  = r_hcnt;
      w_score_nxt = 1'b0;
`ifdef BULLET_BOUNCE_EN
      w_bounce_nxt = r_bounce;
`endif
      if (w_tick) begin
         case (r_state)
            ST_IDLE: begin
               if (r_cool != '0) begin
                  w_cool_nxt = r_cool - CW'(1);
               end else if (fire && dir_valid(tank_dir)) begin
                  w_state_nxt = ST_FLY;
                  w_dir_nxt   = dir_t'(tank_dir);
                  w_bx_nxt    = tankX + L_LAUNCH;
                  w_by_nxt    = tankY + L_LAUNCH;
                  w_hit_nxt   = HIT_FLY;
`ifdef BULLET_BOUNCE_EN
                  w_bounce_nxt = 1'b0;
`endif
               end
            end
            ST_FLY: begin
               if (w_opp_hit) begin
                  w_bx_nxt    = w_mx;
                  w_by_nxt    = w_my;
                  w_hit_nxt   = HIT_TANK;
                  w_score_nxt = 1'b1;
                  w_hcnt_nxt  = '0;
                  w_state_nxt = ST_HIT;
               end else if (w_block) begin
`ifdef BULLET_BOUNCE_EN
                  if (!r_bounce) begin
                     w_dir_nxt    = dir_reverse(r_dir);
                     w_bounce_nxt = 1'b1;
                  end else begin
                     w_hit_nxt   = HIT_WALL;
                     w_hcnt_nxt  = '0;
                     w_state_nxt = ST_HIT;
                  end
`else
                  w_hit_nxt   = HIT_WALL;
                  w_hcnt_nxt  = '0;
                  w_state_nxt = ST_HIT;
`endif
               end else begin
                  w_bx_nxt = w_mx;
                  w_by_nxt = w_my;
               end
            end
            ST_HIT: begin
               if (r_hcnt == HCW'(HIT_FRAMES - 1)) begin
                  w_state_nxt = ST_IDLE;
                  w_hit_nxt   = HIT_IDLE;
                  w_cool_nxt  = CW'(COOLDOWN);
               end else begin
                  w_hcnt_nxt = r_hcnt + HCW'(1);
               end
            end
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

   assign bulletX     = r_bx;
   assign bulletY     = r_by;
   assign hit         = r_hit;
   assign score_pulse = r_score;
   assign is_bullet   = (r_hit == HIT_FLY) &&
                        (DrawX >= r_bx) && ({1'b0, DrawX} < ({1'b0, r_bx} + {1'b0, L_BSIZE})) &&
                        (DrawY >= r_by) && ({1'b0, DrawY} < ({1'b0, r_by} + {1'b0, L_BSIZE}));
endmodule

// File: tb/tb_bullet_ctrl.sv
// tb/tb_bullet_ctrl.sv - scoreboard bench for bullet_ctrl launch, flight, collisions and cooldown
module tb_bullet_ctrl;
   logic       Clk = 1'b0;
   logic       Reset = 1'b1;
   logic       frame_clk = 1'b0;
   logic       fire = 1'b0;
   logic [2:0] tank_dir = 3'b010;
   logic [9:0] tankX = 10'd100, tankY = 10'd100;
   logic [9:0] oppX = 10'd0, oppY = 10'd400;
   logic [9:0] wallX1 = 10'd500, wallX2 = 10'd500, wallX3 = 10'd570, wallX4 = 10'd570;
   logic [9:0] wallY1 = 10'd300, wallY2 = 10'd340, wallY3 = 10'd300, wallY4 = 10'd340;
   logic [9:0] DrawX = 10'd0, DrawY = 10'd0;
   logic [9:0] bulletX, bulletY;
   logic [1:0] hit;
   logic       is_bullet, score_pulse;

   int n_cmp = 0;
   int n_err = 0;
   int pulse_cnt = 0;
   int step_id = 0;

   typedef struct {
      logic       f;
      logic       cp;
      logic [9:0] x;
      logic [9:0] y;
      logic [1:0] h;
   } exp_t;
   exp_t exp_q[$];

   bullet_ctrl dut (
      .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .fire(fire), .tank_dir(tank_dir),
      .tankX(tankX), .tankY(tankY), .oppX(oppX), .oppY(oppY),
      .wallX1(wallX1), .wallX2(wallX2), .wallX3(wallX3), .wallX4(wallX4),
      .wallY1(wallY1), .wallY2(wallY2), .wallY3(wallY3), .wallY4(wallY4),
      .DrawX(DrawX), .DrawY(DrawY), .bulletX(bulletX), .bulletY(bulletY),
      .hit(hit), .is_bullet(is_bullet), .score_pulse(score_pulse)
   );

   always #5 Clk = ~Clk;

   always @(negedge Clk) if (score_pulse) pulse_cnt++;

   task automatic do_reset();
      @(negedge Clk);
      Reset = 1'b1;
      frame_clk = 1'b0;
      repeat (3) @(negedge Clk);
      Reset = 1'b0;
      @(negedge Clk);
   endtask

   task automatic do_tick();
      frame_clk = 1'b1;
      repeat (4) @(negedge Clk);
      frame_clk = 1'b0;
      repeat (4) @(negedge Clk);
   endtask

   task automatic push(input logic f, input logic cp, input int x, input int y, input int h);
      exp_t e;
      e.f = f; e.cp = cp; e.x = 10'(x); e.y = 10'(y); e.h = 2'(h);
      exp_q.push_back(e);
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++; if (hit !== 2'b00) begin n_err++; $display("FAIL reset_hit got %b want 00", hit); end
      n_cmp++; if (bulletX !== 10'd0) begin n_err++; $display("FAIL reset_x got %0d want 0", bulletX); end
      n_cmp++; if (bulletY !== 10'd0) begin n_err++; $display("FAIL reset_y got %0d want 0", bulletY); end
      n_cmp++; if (score_pulse !== 1'b0) begin n_err++; $display("FAIL reset_score got %b want 0", score_pulse); end
      n_cmp++; if (is_bullet !== 1'b0) begin n_err++; $display("FAIL reset_is_bullet got %b want 0", is_bullet); end
   endtask

   task automatic test_launch_move();
      exp_t e;
      int px[5] = '{120, 127, 128, 120, 119};
      int py[5] = '{112, 119, 112, 120, 115};
      logic pe[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      tankX = 10'd100; tankY = 10'd100; tank_dir = 3'b010;
      push(1, 1, 112, 112, 1); push(0, 1, 116, 112, 1); push(0, 1, 120, 112, 1);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); fire = e.f; do_tick(); step_id++;
         n_cmp++;
         if ({bulletX, bulletY, hit} !== {e.x, e.y, e.h}) begin
            n_err++; $display("FAIL launch_move step%0d got x=%0d y=%0d hit=%b want x=%0d y=%0d hit=%b",
                              step_id, bulletX, bulletY, hit, e.x, e.y, e.h);
         end
      end
      for (int i = 0; i < 5; i++) begin
         DrawX = 10'(px[i]); DrawY = 10'(py[i]); #1;
         n_cmp++;
         if (is_bullet !== pe[i]) begin
            n_err++; $display("FAIL is_bullet (%0d,%0d) got %b want %b", px[i], py[i], is_bullet, pe[i]);
         end
      end
      DrawX = 10'd0; DrawY = 10'd0;
   endtask

   task automatic test_reset_in_fly();
      exp_t e;
      do_reset();
      n_cmp++;
      if ({bulletX, bulletY, hit} !== 22'd0) begin
         n_err++; $display("FAIL reset_in_fly got x=%0d y=%0d hit=%b want 0 0 00", bulletX, bulletY, hit);
      end
      push(0, 0, 0, 0, 0); push(1, 1, 112, 112, 1);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); fire = e.f; do_tick(); step_id++;
         n_cmp++;
         if (e.cp ? ({bulletX, bulletY, hit} !== {e.x, e.y, e.h}) : (hit !== e.h)) begin
            n_err++; $display("FAIL reset_relaunch step%0d got x=%0d y=%0d hit=%b want x=%0d y=%0d hit=%b",
                              step_id, bulletX, bulletY, hit, e.x, e.y, e.h);
         end
      end
      fire = 1'b0;
      do_reset();
   endtask

   task automatic test_edge_up_cooldown();
      exp_t e;
      tankX = 10'd200; tankY = 10'd0; tank_dir = 3'b001;
      push(1, 1, 212, 12, 1); push(0, 1, 212, 8, 1); push(0, 1, 212, 4, 1); push(0, 1, 212, 0, 1);
      push(0, 1, 212, 0, 2);
      for (int i = 0; i < 7; i++) push(1, 1, 212, 0, 2);
      push(1, 0, 0, 0, 0);
      for (int i = 0; i < 16; i++) push(1, 0, 0, 0, 0);
      push(1, 1, 212, 12, 1);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); fire = e.f; do_tick(); step_id++;
         n_cmp++;
         if (e.cp ? ({bulletX, bulletY, hit} !== {e.x, e.y, e.h}) : (hit !== e.h)) begin
            n_err++; $display("FAIL edge_up_cooldown step%0d got x=%0d y=%0d hit=%b want x=%0d y=%0d hit=%b",
                              step_id, bulletX, bulletY, hit, e.x, e.y, e.h);
         end
      end
      fire = 1'b0;
      do_reset();
   endtask

   task automatic test_edge_right();
      exp_t e;
      tankX = 10'd600; tankY = 10'd200; tank_dir = 3'b010;
      push(1, 1, 612, 212, 1);
      for (int x = 616; x <= 632; x += 4) push(0, 1, x, 212, 1);
      push(0, 1, 632, 212, 2);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); fire = e.f; do_tick(); step_id++;
         n_cmp++;
         if ({bulletX, bulletY, hit} !== {e.x, e.y, e.h}) begin
            n_err++; $display("FAIL edge_right step%0d got x=%0d y=%0d hit=%b want x=%0d y=%0d hit=%b",
                              step_id, bulletX, bulletY, hit, e.x, e.y, e.h);
         end
      end
      do_reset();
   endtask

   task automatic test_priority();
      exp_t e;
      int p0;
      tankX = 10'd100; tankY = 10'd100; tank_dir = 3'b010;
      wallX1 = 10'd118; wallY1 = 10'd100; oppX = 10'd120; oppY = 10'd100;
      p0 = pulse_cnt;
      push(1, 1, 112, 112, 1); push(0, 1, 116, 112, 3);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); fire = e.f; do_tick(); step_id++;
         n_cmp++;
         if ({bulletX, bulletY, hit} !== {e.x, e.y, e.h}) begin
            n_err++; $display("FAIL priority step%0d got x=%0d y=%0d hit=%b want x=%0d y=%0d hit=%b",
                              step_id, bulletX, bulletY, hit, e.x, e.y, e.h);
         end
      end
      n_cmp++;
      if (pulse_cnt - p0 !== 1) begin
         n_err++; $display("FAIL score_pulse_cycles got %0d want 1", pulse_cnt - p0);
      end
      wallX1 = 10'd500; wallY1 = 10'd300; oppX = 10'd0; oppY = 10'd400;
      do_reset();
   endtask

   task automatic test_wall_bounce();
      exp_t e;
      int p0;
      tankX = 10'd100; tankY = 10'd100; tank_dir = 3'b010;
      wallX2 = 10'd130; wallY2 = 10'd90;
      p0 = pulse_cnt;
      push(1, 1, 112, 112, 1); push(0, 1, 116, 112, 1); push(0, 1, 120, 112, 1);
`ifdef BULLET_BOUNCE_EN
      push(0, 1, 120, 112, 1);
      for (int x = 116; x >= 0; x -= 4) push(0, 1, x, 112, 1);
      push(0, 1, 0, 112, 2);
`else
      push(0, 1, 120, 112, 2);
`endif
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); fire = e.f; do_tick(); step_id++;
         n_cmp++;
         if ({bulletX, bulletY, hit} !== {e.x, e.y, e.h}) begin
            n_err++; $display("FAIL wall_bounce step%0d got x=%0d y=%0d hit=%b want x=%0d y=%0d hit=%b",
                              step_id, bulletX, bulletY, hit, e.x, e.y, e.h);
         end
      end
      n_cmp++;
      if (pulse_cnt !== p0) begin
         n_err++; $display("FAIL wall_no_score got %0d want 0", pulse_cnt - p0);
      end
      wallX2 = 10'd500; wallY2 = 10'd340;
      do_reset();
   endtask

   task automatic test_invalid_dir();
      exp_t e;
      logic [2:0] dirs[5] = '{3'b000, 3'b101, 3'b110, 3'b111, 3'b010};
      tankX = 10'd100; tankY = 10'd100;
      for (int i = 0; i < 4; i++) push(1, 0, 0, 0, 0);
      push(1, 1, 112, 112, 1);
      for (int i = 0; i < 5; i++) begin
         e = exp_q.pop_front(); fire = e.f; tank_dir = dirs[i]; do_tick(); step_id++;
         n_cmp++;
         if (e.cp ? ({bulletX, bulletY, hit} !== {e.x, e.y, e.h}) : (hit !== e.h)) begin
            n_err++; $display("FAIL invalid_dir dir=%b got x=%0d y=%0d hit=%b want x=%0d y=%0d hit=%b",
                              dirs[i], bulletX, bulletY, hit, e.x, e.y, e.h);
         end
      end
      fire = 1'b0;
      do_reset();
   endtask

   initial begin
      test_reset();
      test_launch_move();
      test_reset_in_fly();
      test_edge_up_cooldown();
      test_edge_right();
      test_priority();
      test_wall_bounce();
      test_invalid_dir();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
